cnn_window_reader: RTL and testbench

- Read-side companion of the CNN input feature memory.
- The memory side holds three row BRAMs, cascaded so that the oldest row sits in BRAM 2 and the newest in BRAM 0.
- This block generates the shared read address and enable for one row pass, collects the three-row column returned each cycle, and assembles 3x3 sliding windows for the convolution engine.
- Windows are delivered over a valid/ready handshake.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/cnn_window_shift_reg.sv | 40 ++++
 rtl/cnn_window_reader.sv | 169 ++++++++++++++++
 tb/tb_cnn_window_reader.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN window reader.
// The window index function fixes the row-major r*3+c layout used on o_window.
package cnn_pkg;

   localparam int unsigned KERNEL_SIZE  = 3;
   localparam int unsigned WINDOW_ELEMS = KERNEL_SIZE * KERNEL_SIZE;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
      return r * KERNEL_SIZE + c;
   endfunction

endpackage

// File: rtl/cnn_window_shift_reg.sv
// 3x3 sliding-window register: each shift moves every row one column left
// and loads a new right-hand column; o_loaded counts columns, saturating at 3.
module cnn_window_shift_reg
   import cnn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_clear,
   input  logic                  i_shift,
   input  logic [DATA_WIDTH-1:0] i_col    [0:KERNEL_SIZE-1],
   output logic [DATA_WIDTH-1:0] o_window [0:WINDOW_ELEMS-1],
   output logic [1:0]            o_loaded
);

   logic [DATA_WIDTH-1:0] r_win [0:WINDOW_ELEMS-1];
   logic [1:0]            r_loaded;

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         for (int unsigned i = 0; i < WINDOW_ELEMS; i++) r_win[i] <= '0;
         r_loaded <= '0;
      end else if (i_clear) begin
         // Stale contents are harmless: three fresh columns overwrite them before use.
         r_loaded <= '0;
      end else if (i_shift) begin
         for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
            r_win[win_idx(r, 0)] <= r_win[win_idx(r, 1)];
            r_win[win_idx(r, 1)] <= r_win[win_idx(r, 2)];
            r_win[win_idx(r, 2)] <= i_col[r];
         end
         if (r_loaded != 2'd3) r_loaded <= r_loaded + 2'd1;
      end
   end

   assign o_window = r_win;
   assign o_loaded = r_loaded;

endmodule

// File: rtl/cnn_window_reader.sv
// Read side of the CNN input feature memory: issues row-pass reads to the three
// cascaded row BRAMs and streams 3x3 windows over a valid/ready handshake.
module cnn_window_reader
   import cnn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned KERNEL_ROW_SIZE  = 3,
   parameter int unsigned INPUT_BRAM_DEPTH = 3072,
   parameter int unsigned ADDR_WIDTH       = $clog2(INPUT_BRAM_DEPTH)
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_address,
   input  logic [ADDR_WIDTH:0]   i_row_width,
   output logic                  o_renable,
   output logic [ADDR_WIDTH-1:0] o_raddress,
   input  logic [DATA_WIDTH-1:0] i_bram_data [0:KERNEL_SIZE-1],
   output logic [DATA_WIDTH-1:0] o_window    [0:WINDOW_ELEMS-1],
   output logic                  o_window_valid,
   input  logic                  i_window_ready,
   output logic [ADDR_WIDTH-1:0] o_window_col,
   output logic                  o_window_last,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error
);

   if (KERNEL_ROW_SIZE != KERNEL_SIZE) begin : g_bad_kernel
      $error("cnn_window_reader supports only KERNEL_ROW_SIZE == 3");
   end

   localparam logic [ADDR_WIDTH:0]   MIN_W   = (ADDR_WIDTH+1)'(KERNEL_SIZE);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(INPUT_BRAM_DEPTH);
   localparam logic [ADDR_WIDTH+1:0] DEPTH_S = (ADDR_WIDTH+2)'(INPUT_BRAM_DEPTH);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH:0]   r_width;
   logic [ADDR_WIDTH:0]   r_issued;
   logic                  r_inflight;
   logic                  r_skid_full;
   logic [DATA_WIDTH-1:0] r_skid [0:KERNEL_SIZE-1];
   logic                  r_valid;
   logic [ADDR_WIDTH-1:0] r_col;
   logic                  r_last;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;

   logic                  w_avail;
   logic                  w_shift;
   logic                  w_renable;
   logic                  w_legal;
   logic                  w_clear;
   logic                  w_emit;
   logic                  w_last_acc;
   logic [1:0]            w_loaded;
   logic [ADDR_WIDTH+1:0] w_sum;
   logic [ADDR_WIDTH-1:0] w_raddr;
   logic [ADDR_WIDTH-1:0] w_next_col;
   logic [DATA_WIDTH-1:0] w_col [0:KERNEL_SIZE-1];

   assign w_avail   = r_skid_full | r_inflight;
   assign w_shift   = w_avail & (~r_valid | i_window_ready);
   // Holding off a read whenever returning data cannot shift keeps the skid at one entry.
   assign w_renable = (r_state == RUN) & (r_issued < r_width) & ~r_skid_full
                    & ~(r_inflight & ~w_shift);
   assign w_legal   = (i_row_width >= MIN_W) && (i_row_width <= DEPTH_W);
   assign w_clear   = (r_state == IDLE) & i_start & w_legal;
   assign w_emit    = w_shift & (w_loaded >= 2'd2);
   assign w_last_acc = r_valid & i_window_ready & r_last;
   assign w_next_col = (w_loaded == 2'd3) ? r_col + ADDR_WIDTH'(1) : '0;

   assign w_sum   = (ADDR_WIDTH+2)'(r_base) + (ADDR_WIDTH+2)'(r_issued);
   assign w_raddr = (w_sum >= DEPTH_S) ? ADDR_WIDTH'(w_sum - DEPTH_S) : ADDR_WIDTH'(w_sum);

   always_comb begin
      for (int unsigned r = 0; r < KERNEL_SIZE; r++)
         w_col[r] = r_skid_full ? r_skid[r] : i_bram_data[KERNEL_SIZE-1-r];
   end

   cnn_window_shift_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shift_reg (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (w_clear),
      .i_shift  (w_shift),
      .i_col    (w_col),
      .o_window (o_window),
      .o_loaded (w_loaded)
   );

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state     <= IDLE;
         r_base      <= '0;
         r_width     <= '0;
         r_issued    <= '0;
         r_inflight  <= 1'b0;
         r_skid_full <= 1'b0;
         for (int unsigned r = 0; r < KERNEL_SIZE; r++) r_skid[r] <= '0;
         r_valid     <= 1'b0;
         r_col       <= '0;
         r_last      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_inflight <= w_renable;
         if (w_renable) r_issued <= r_issued + (ADDR_WIDTH+1)'(1);

         if (r_skid_full && w_shift) begin
            r_skid_full <= 1'b0;
         end else if (r_inflight && !w_shift) begin
            r_skid_full <= 1'b1;
            for (int unsigned r = 0; r < KERNEL_SIZE; r++)
               r_skid[r] <= i_bram_data[KERNEL_SIZE-1-r];
         end

         if (w_emit) begin
            r_valid <= 1'b1;
            r_col   <= w_next_col;
            r_last  <= ({1'b0, w_next_col} == (r_width - MIN_W));
         end else if (r_valid && i_window_ready) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (i_start) begin
                  if (w_legal) begin
                     r_state  <= RUN;
                     r_base   <= i_base_address;
                     r_width  <= i_row_width;
                     r_issued <= '0;
                     r_error  <= 1'b0;
                     r_busy   <= 1'b1;
                  end else begin
                     r_error <= 1'b1;
                     r_done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if ((r_issued == r_width) && !r_skid_full && !r_inflight && w_last_acc) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_renable      = w_renable;
   assign o_raddress     = w_raddr;
   assign o_window_valid = r_valid;
   assign o_window_col   = r_col;
   assign o_window_last  = r_last;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_error        = r_error;

endmodule

// File: tb/tb_cnn_window_reader.sv
// Self-checking bench for cnn_window_reader: a BRAM model feeds the DUT and a
// reference model builds the expected windows straight from memory contents.
module tb_cnn_window_reader;
   import cnn_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 3072;
   localparam int AW    = 12;

   typedef struct packed {
      logic [9*DW-1:0] w;
      logic [AW-1:0]   col;
      logic            last;
   } win_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_in;
   logic [AW:0]   width_in;
   logic          renable;
   logic [AW-1:0] raddr;
   logic [DW-1:0] bram_q [0:2];
   logic [DW-1:0] window [0:8];
   logic          valid;
   logic          ready;
   logic [AW-1:0] wcol;
   logic          wlast;
   logic          busy;
   logic          done;
   logic          error;

   always #5 clk = ~clk;

   cnn_window_reader #(
      .DATA_WIDTH       (DW),
      .KERNEL_ROW_SIZE  (3),
      .INPUT_BRAM_DEPTH (DEPTH),
      .ADDR_WIDTH       (AW)
   ) dut (
      .i_clock        (clk),
      .i_reset        (rst_n),
      .i_start        (start),
      .i_base_address (base_in),
      .i_row_width    (width_in),
      .o_renable      (renable),
      .o_raddress     (raddr),
      .i_bram_data    (bram_q),
      .o_window       (window),
      .o_window_valid (valid),
      .i_window_ready (ready),
      .o_window_col   (wcol),
      .o_window_last  (wlast),
      .o_busy         (busy),
      .o_done         (done),
      .o_error        (error)
   );

   logic [DW-1:0] mem [0:2][0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (renable)
         for (int k = 0; k < 3; k++) bram_q[k] <= mem[k][raddr];
   end

   int   errors = 0;
   int   checks = 0;
   win_t got[$];
   win_t exp_q[$];
   int   addrs[$];
   int   n_ren, n_done, stall_err;
   int   first_ren_it, first_val_it, last_acc_it, done_it;
   bit   busy_seen, timeout;

   task automatic fill_pattern();
      for (int a = 0; a < DEPTH; a++) begin
         mem[0][a] = 32'h100 + a;
         mem[1][a] = 32'h200 + a;
         mem[2][a] = 32'h300 + a;
      end
   endtask

   task automatic fill_random();
      for (int a = 0; a < DEPTH; a++)
         for (int k = 0; k < 3; k++) mem[k][a] = $urandom;
   endtask

   // Window j of a pass covers columns base+j .. base+j+2; row 0 is the oldest (BRAM 2).
   task automatic model_pass(input int b, input int w);
      win_t e;
      exp_q.delete();
      for (int j = 0; j <= w - 3; j++) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               e.w[(r*3+c)*DW +: DW] = mem[2-r][(b + j + c) % DEPTH];
         e.col  = AW'(j);
         e.last = (j == w - 3);
         exp_q.push_back(e);
      end
   endtask

   // mode 0: ready high; 1: ready 1,0,0,1 repeating; 2: random ready.
   task automatic run_pass(input int b, input int w, input int mode, input int inj_it);
      win_t cur, prev;
      bit   prev_stall;
      int   post;
      got.delete(); addrs.delete();
      n_ren = 0; n_done = 0; stall_err = 0; busy_seen = 0; timeout = 0;
      first_ren_it = -1; first_val_it = -1; last_acc_it = -1; done_it = -1;
      prev_stall = 0; prev = '0; post = -1;
      @(negedge clk);
      start = 1'b1; base_in = AW'(b); width_in = (AW+1)'(w); ready = 1'b1;
      for (int it = 1; it < 8000; it++) begin
         @(negedge clk);
         start = 1'b0;
         if (it == inj_it) begin
            start = 1'b1; base_in = AW'(b + 7); width_in = (AW+1)'(10);
         end
         case (mode)
            0:       ready = 1'b1;
            1:       ready = (it % 4 == 1) || (it % 4 == 0);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         for (int i = 0; i < 9; i++) cur.w[i*DW +: DW] = window[i];
         cur.col = wcol; cur.last = wlast;
         if (renable) begin
            addrs.push_back(int'(raddr)); n_ren++;
            if (first_ren_it < 0) first_ren_it = it;
         end
         if (busy) busy_seen = 1;
         if (valid && first_val_it < 0) first_val_it = it;
         if (prev_stall && !(valid && cur == prev)) stall_err++;
         if (valid && ready) begin
            got.push_back(cur);
            if (wlast) last_acc_it = it;
         end
         prev_stall = valid && !ready;
         prev = cur;
         if (done) begin
            n_done++;
            if (done_it < 0) begin done_it = it; post = it + 4; end
         end
         if (post > 0 && it >= post) break;
      end
      start = 1'b0;
      if (post < 0) timeout = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; ready = 1'b0; base_in = '0; width_in = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({renable, valid, busy, done, error, wlast} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=000000", {renable, valid, busy, done, error, wlast});
      end
      checks++;
      if (raddr !== '0 || wcol !== '0) begin
         errors++; $display("FAIL reset_addr_col got=%0d/%0d exp=0/0", raddr, wcol);
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (window[i] !== '0) begin
            errors++; $display("FAIL reset_window[%0d] got=%h exp=0", i, window[i]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      fill_pattern();
      run_pass(0, 5, 0, -1);
      model_pass(0, 5);
      checks++;
      if (timeout || got.size() != 3) begin
         errors++; $display("FAIL basic_count got=%0d exp=3 timeout=%0d", got.size(), timeout);
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++; $display("FAIL basic_win[%0d] got=%h exp=%h", i, got[i], exp_q[i]);
         end
      end
      if (got.size() > 0) begin
         checks++;
         if (got[0].w[0 +: DW] !== 32'h300 || got[0].w[8*DW +: DW] !== 32'h102) begin
            errors++;
            $display("FAIL basic_corner got=%h/%h exp=300/102", got[0].w[0 +: DW], got[0].w[8*DW +: DW]);
         end
      end
      checks++;
      if (first_val_it != first_ren_it + 4) begin
         errors++; $display("FAIL basic_latency got=%0d exp=%0d", first_val_it, first_ren_it + 4);
      end
      checks++;
      if (done_it != last_acc_it + 1 || n_done != 1) begin
         errors++;
         $display("FAIL basic_done got=%0d(x%0d) exp=%0d(x1)", done_it, n_done, last_acc_it + 1);
      end
      checks++;
      if (!busy_seen) begin errors++; $display("FAIL basic_busy got=0 exp=1"); end
   endtask

   task automatic test_backpressure();
      fill_random();
      run_pass(100, 8, 1, -1);
      model_pass(100, 8);
      checks++;
      if (timeout || got.size() != 6) begin
         errors++; $display("FAIL bp_count got=%0d exp=6 timeout=%0d", got.size(), timeout);
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++; $display("FAIL bp_win[%0d] got=%h exp=%h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (stall_err != 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
      checks++;
      if (n_ren != 8) begin errors++; $display("FAIL bp_reads got=%0d exp=8", n_ren); end
      for (int i = 0; i < addrs.size(); i++) begin
         checks++;
         if (addrs[i] != (100 + i) % DEPTH) begin
            errors++; $display("FAIL bp_addr[%0d] got=%0d exp=%0d", i, addrs[i], 100 + i);
         end
      end
   endtask

   task automatic test_illegal();
      run_pass(10, 2, 0, -1);
      checks++;
      if (error !== 1'b1) begin errors++; $display("FAIL illegal_error got=%b exp=1", error); end
      checks++;
      if (n_done != 1 || done_it != 1) begin
         errors++; $display("FAIL illegal_done got=%0d@%0d exp=1@1", n_done, done_it);
      end
      checks++;
      if (n_ren != 0 || busy_seen || got.size() != 0) begin
         errors++;
         $display("FAIL illegal_quiet got=ren%0d busy%0d win%0d exp=0/0/0", n_ren, busy_seen, got.size());
      end
      run_pass(0, DEPTH + 1, 0, -1);
      checks++;
      if (error !== 1'b1 || n_ren != 0) begin
         errors++; $display("FAIL illegal_wide got=err%b ren%0d exp=1/0", error, n_ren);
      end
   endtask

   task automatic test_wrap();
      fill_random();
      run_pass(3070, 4, 0, -1);
      model_pass(3070, 4);
      checks++;
      if (error !== 1'b0) begin errors++; $display("FAIL wrap_error_clear got=%b exp=0", error); end
      checks++;
      if (addrs.size() != 4) begin errors++; $display("FAIL wrap_nreads got=%0d exp=4", addrs.size()); end
      for (int i = 0; i < addrs.size(); i++) begin
         checks++;
         if (addrs[i] != (3070 + i) % DEPTH) begin
            errors++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, addrs[i], (3070 + i) % DEPTH);
         end
      end
      checks++;
      if (got.size() != 2 || got != exp_q) begin
         errors++; $display("FAIL wrap_windows got=%0d exp=2 (data differs or count)", got.size());
      end
   endtask

   task automatic test_reset_midpass();
      int acc = 0;
      int dn = 0;
      int ren_idle = 0;
      fill_random();
      @(negedge clk);
      start = 1'b1; base_in = AW'(50); width_in = (AW+1)'(20); ready = 1'b1;
      for (int it = 0; it < 200 && acc < 5; it++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (valid && ready) acc++;
      end
      checks++;
      if (acc != 5) begin errors++; $display("FAIL midrst_reach got=%0d exp=5", acc); end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({renable, valid, busy, done, error, wlast} !== 6'b0 || raddr !== '0 || wcol !== '0) begin
         errors++;
         $display("FAIL midrst_outputs got=%b a%0d c%0d exp=000000 a0 c0",
                  {renable, valid, busy, done, error, wlast}, raddr, wcol);
      end
      rst_n = 1'b1;
      repeat (30) begin
         @(negedge clk);
         #1;
         if (done) dn++;
         if (renable) ren_idle++;
      end
      checks++;
      if (dn != 0 || ren_idle != 0) begin
         errors++; $display("FAIL midrst_no_done got=done%0d ren%0d exp=0/0", dn, ren_idle);
      end
      run_pass(5, 3, 0, -1);
      model_pass(5, 3);
      checks++;
      if (timeout || got.size() != 1 || got != exp_q) begin
         errors++; $display("FAIL midrst_restart got=%0d exp=1 timeout=%0d", got.size(), timeout);
      end
   endtask

   task automatic test_start_ignored();
      fill_random();
      run_pass(200, 6, 0, 3);
      model_pass(200, 6);
      checks++;
      if (timeout || got.size() != 4) begin
         errors++; $display("FAIL ign_count got=%0d exp=4 timeout=%0d", got.size(), timeout);
      end
      checks++;
      if (got != exp_q) begin errors++; $display("FAIL ign_windows got=%0d windows exp=model", got.size()); end
      checks++;
      if (n_ren != 6 || n_done != 1) begin
         errors++; $display("FAIL ign_reads got=%0d/%0d exp=6/1", n_ren, n_done);
      end
   endtask

   task automatic test_random();
      for (int p = 0; p < 5; p++) begin
         int b = $urandom_range(0, DEPTH - 1);
         int w = (p == 4) ? DEPTH : $urandom_range(3, 40);
         fill_random();
         run_pass(b, w, (p == 4) ? 0 : 2, -1);
         model_pass(b, w);
         checks++;
         if (timeout || got.size() != w - 2 || got != exp_q) begin
            errors++;
            $display("FAIL rand%0d_windows got=%0d exp=%0d (b=%0d w=%0d timeout=%0d)",
                     p, got.size(), w - 2, b, w, timeout);
         end
         checks++;
         if (stall_err != 0 || n_done != 1) begin
            errors++; $display("FAIL rand%0d_hs got=stall%0d done%0d exp=0/1", p, stall_err, n_done);
         end
         checks++;
         if (addrs.size() != w || addrs[addrs.size()-1] != (b + w - 1) % DEPTH) begin
            errors++; $display("FAIL rand%0d_addr got=%0d reads exp=%0d", p, addrs.size(), w);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_illegal();
      test_wrap();
      test_reset_midpass();
      test_start_ignored();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
